// File: rtl/temp_pkg.sv
// Shared definitions for the temperature polling scheduler: state encoding,
// temperature field layout and the alert comparison.
package temp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RETRY = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_RETRY = RETRY;

  localparam int TEMP_MSB = 15;
  localparam int TEMP_LSB = 4;
  localparam int TEMP_W   = TEMP_MSB - TEMP_LSB + 1;

  localparam logic [7:0] SNS_ADDR = 8'h91;

  // Signed compare of the 12-bit temperature field against the alert limit.
  function automatic logic temp_at_or_above(input logic [15:0]       sample,
                                            input logic [TEMP_W-1:0] limit);
    logic signed [TEMP_W-1:0] t;
    logic signed [TEMP_W-1:0] l;
    t = $signed(sample[TEMP_MSB:TEMP_LSB]);
    l = $signed(limit);
    return t >= l;
  endfunction

endpackage

// File: rtl/temp_poll_timer.sv
// Free-running sample period counter; tick marks the last cycle of each period
// and the count is held at zero while disabled.
module temp_poll_timer #(
  parameter int PERIOD_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(PERIOD_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == TERM);

endmodule

// File: rtl/temp_poll_ctrl.sv
// Schedules temperature-sensor reads (periodic and on request) with timeout
// and bounded retry, holding the last good sample and an over-temp alert.
module temp_poll_ctrl
  import temp_pkg::*;
#(
  parameter int PERIOD_CYCLES  = 100000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRY      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        req,
  input  logic [11:0] thresh,
  input  logic        err_clr,
  output logic        sns_start,
  input  logic        sns_done,
  input  logic        sns_nack,
  input  logic [15:0] sns_data,
  output logic [15:0] temp,
  output logic        temp_valid,
  output logic        alert,
  output logic        err,
  output logic        busy
);

  localparam int WCW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);
  localparam logic [RCW-1:0] RETRY_MAX = RCW'(MAX_RETRY);

  logic           tick;
  logic [1:0]     state_q,   state_d;
  logic           pending_q, pending_d;
  logic [WCW-1:0] wait_q,    wait_d;
  logic [RCW-1:0] retry_q,   retry_d;
  logic [15:0]    temp_q,    temp_d;
  logic           tv_q,      tv_d;
  logic           alert_q,   alert_d;
  logic           err_q,     err_d;
  logic           launch;
  logic           give_up;

  temp_poll_timer #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    retry_d = retry_q;
    temp_d  = temp_q;
    tv_d    = 1'b0;
    alert_d = alert_q;
    launch  = 1'b0;
    give_up = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d = ST_ISSUE;
          retry_d = '0;
          launch  = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        wait_d  = '0;
      end
      ST_WAIT: begin
        wait_d = wait_q + 1'b1;
        // A good completion on the timeout cycle still counts as success.
        if (sns_done && !sns_nack) begin
          temp_d  = sns_data;
          tv_d    = 1'b1;
          alert_d = temp_at_or_above(sns_data, thresh);
          state_d = ST_IDLE;
        end else if ((sns_done && sns_nack) || (wait_q == WAIT_LAST)) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_RETRY;
          end else begin
            give_up = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_RETRY: begin
        state_d = ST_ISSUE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Requests landing while a transaction runs fold into one follow-up.
  assign pending_d = (pending_q && !launch) || tick || req;
  assign err_d     = give_up || (err_q && !err_clr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      wait_q    <= '0;
      retry_q   <= '0;
      temp_q    <= '0;
      tv_q      <= 1'b0;
      alert_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      wait_q    <= wait_d;
      retry_q   <= retry_d;
      temp_q    <= temp_d;
      tv_q      <= tv_d;
      alert_q   <= alert_d;
      err_q     <= err_d;
    end
  end

  assign sns_start  = (state_q == ST_ISSUE);
  assign busy       = (state_q != ST_IDLE);
  assign temp       = temp_q;
  assign temp_valid = tv_q;
  assign alert      = alert_q;
  assign err        = err_q;

endmodule

// File: tb/tb_temp_poll_ctrl.sv
// Directed bench for temp_poll_ctrl with a timeline-based reference model and
// a scripted sensor responder.
module tb_temp_poll_ctrl;

  localparam int P  = 20;
  localparam int T  = 8;
  localparam int MR = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        req = 1'b0;
  logic [11:0] thresh = 12'h190;
  logic        err_clr = 1'b0;
  logic        sns_start;
  logic        sns_done = 1'b0;
  logic        sns_nack = 1'b0;
  logic [15:0] sns_data = 16'h0000;
  logic [15:0] temp;
  logic        temp_valid;
  logic        alert;
  logic        err;
  logic        busy;

  always #5 clk = ~clk;

  temp_poll_ctrl #(
    .PERIOD_CYCLES (P),
    .TIMEOUT_CYCLES(T),
    .MAX_RETRY     (MR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req       (req),
    .thresh    (thresh),
    .err_clr   (err_clr),
    .sns_start (sns_start),
    .sns_done  (sns_done),
    .sns_nack  (sns_nack),
    .sns_data  (sns_data),
    .temp      (temp),
    .temp_valid(temp_valid),
    .alert     (alert),
    .err       (err),
    .busy      (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Sensor responder: each start pops one scripted reply; empty script = silence.
  typedef struct {
    logic        nack;
    logic [15:0] data;
    int          dly;
  } resp_t;
  resp_t rq[$];

  initial begin : responder
    int    cnt;
    resp_t cur;
    cnt = 0;
    cur = '{nack: 1'b0, data: 16'h0000, dly: 0};
    forever begin
      @(negedge clk);
      sns_done = 1'b0;
      sns_nack = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          sns_done = 1'b1;
          sns_nack = cur.nack;
          sns_data = cur.data;
        end
      end
      if (sns_start === 1'b1 && rq.size() > 0) begin
        cur = rq.pop_front();
        cnt = cur.dly;
      end
    end
  end

  // Reference model: transaction timeline in absolute cycle numbers.
  int          m_cyc;
  int          m_run;
  bit          m_pend;
  bit          m_infl;
  int          m_issue;
  int          m_att;
  logic [15:0] m_temp;
  bit          m_tv;
  bit          m_alert;
  bit          m_err;

  initial begin : model
    int c;
    bit tick;
    bit was_idle;
    bit set_err;
    bit launch;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_cyc = 0; m_run = 0; m_pend = 0; m_infl = 0; m_issue = 0; m_att = 0;
        m_temp = 16'h0000; m_tv = 0; m_alert = 0; m_err = 0;
      end else begin
        c = m_cyc;
        tick = enable && ((m_run % P) == P - 1);
        m_run = enable ? m_run + 1 : 0;
        was_idle = !m_infl;
        m_tv = 0;
        set_err = 0;
        if (m_infl && c > m_issue) begin
          if (sns_done && !sns_nack) begin
            m_temp  = sns_data;
            m_tv    = 1;
            m_alert = ($signed(sns_data[15:4]) >= $signed(thresh));
            m_infl  = 0;
          end else if ((sns_done && sns_nack) || c == m_issue + T) begin
            if (m_att < MR) begin
              m_att++;
              m_issue = c + 2;
            end else begin
              set_err = 1;
              m_infl  = 0;
            end
          end
        end
        if (err_clr) m_err = 0;
        if (set_err) m_err = 1;
        launch = was_idle && m_pend;
        if (launch) begin
          m_infl  = 1;
          m_issue = c + 1;
          m_att   = 0;
        end
        m_pend = (m_pend && !launch) || tick || req;
        m_cyc  = c + 1;
      end
    end
  end

  int st_cyc[$];
  int n_tv = 0;

  initial begin : compare
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        chk("cyc_sns_start", 32'(sns_start), 32'(m_infl && (m_cyc == m_issue)));
        chk("cyc_busy", 32'(busy), 32'(m_infl));
        chk("cyc_temp_valid", 32'(temp_valid), 32'(m_tv));
        chk("cyc_temp", 32'(temp), 32'(m_temp));
        chk("cyc_alert", 32'(alert), 32'(m_alert));
        chk("cyc_err", 32'(err), 32'(m_err));
        if (sns_start === 1'b1) st_cyc.push_back(m_cyc);
        if (temp_valid === 1'b1) n_tv++;
      end
    end
  end

  function automatic int gap(input int i);
    if (st_cyc.size() > i + 1) return st_cyc[i + 1] - st_cyc[i];
    return -1;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_tv(input string name, input int maxc);
    bit ok;
    ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (temp_valid === 1'b1) ok = 1;
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_start(input string name, input int maxc);
    bit ok;
    ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (sns_start === 1'b1) ok = 1;
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : stim
    int b;
    int tvb;

    cycles(3);
    chk("rst_sns_start", 32'(sns_start), 32'd0);
    chk("rst_temp", 32'(temp), 32'd0);
    chk("rst_temp_valid", 32'(temp_valid), 32'd0);
    chk("rst_alert", 32'(alert), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    cycles(2);

    // Periodic sampling with alert set then cleared.
    rq.push_back('{nack: 1'b0, data: 16'h1900, dly: 5});
    rq.push_back('{nack: 1'b0, data: 16'h1900, dly: 5});
    rq.push_back('{nack: 1'b0, data: 16'hE700, dly: 5});
    b = st_cyc.size();
    tvb = n_tv;
    enable = 1'b1;
    wait_tv("per_tv1", 45);
    chk("per_temp1", 32'(temp), 32'h1900);
    chk("per_alert1", 32'(alert), 32'd1);
    wait_tv("per_tv2", 30);
    chk("per_temp2", 32'(temp), 32'h1900);
    wait_tv("per_tv3", 30);
    chk("per_temp3", 32'(temp), 32'hE700);
    chk("per_alert3", 32'(alert), 32'd0);
    enable = 1'b0;
    chk("per_starts", 32'(st_cyc.size() - b), 32'd3);
    chk("per_gap1", 32'(gap(b)), 32'd20);
    chk("per_gap2", 32'(gap(b + 1)), 32'd20);
    cycles(5);
    chk("per_tv_count", 32'(n_tv - tvb), 32'd3);

    // Two NACKs then a good read.
    rq.push_back('{nack: 1'b1, data: 16'hDEAD, dly: 3});
    rq.push_back('{nack: 1'b1, data: 16'hDEAD, dly: 3});
    rq.push_back('{nack: 1'b0, data: 16'h0A00, dly: 3});
    b = st_cyc.size();
    pulse_req();
    wait_tv("retry_tv", 40);
    chk("retry_temp", 32'(temp), 32'h0A00);
    chk("retry_err", 32'(err), 32'd0);
    chk("retry_alert", 32'(alert), 32'd0);
    chk("retry_starts", 32'(st_cyc.size() - b), 32'd3);
    chk("retry_gap1", 32'(gap(b)), 32'd5);
    chk("retry_gap2", 32'(gap(b + 1)), 32'd5);
    cycles(3);

    // Silent sensor: all attempts time out.
    b = st_cyc.size();
    tvb = n_tv;
    pulse_req();
    cycles(45);
    chk("exh_starts", 32'(st_cyc.size() - b), 32'd3);
    chk("exh_gap1", 32'(gap(b)), 32'd10);
    chk("exh_gap2", 32'(gap(b + 1)), 32'd10);
    chk("exh_err", 32'(err), 32'd1);
    chk("exh_no_tv", 32'(n_tv - tvb), 32'd0);
    chk("exh_temp", 32'(temp), 32'h0A00);
    chk("exh_busy", 32'(busy), 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("exh_err_clr", 32'(err), 32'd0);

    // Three requests during WAIT coalesce into one follow-up.
    rq.push_back('{nack: 1'b0, data: 16'h0C80, dly: 6});
    rq.push_back('{nack: 1'b0, data: 16'h0C80, dly: 6});
    b = st_cyc.size();
    tvb = n_tv;
    pulse_req();
    wait_start("coal_first_start", 10);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
    end
    cycles(40);
    chk("coal_starts", 32'(st_cyc.size() - b), 32'd2);
    chk("coal_tv", 32'(n_tv - tvb), 32'd2);
    chk("coal_temp", 32'(temp), 32'h0C80);

    // req and tick in the same cycle give one transaction.
    rq.push_back('{nack: 1'b0, data: 16'h1900, dly: 5});
    b = st_cyc.size();
    tvb = n_tv;
    enable = 1'b1;
    cycles(19);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    enable = 1'b0;
    cycles(30);
    chk("same_starts", 32'(st_cyc.size() - b), 32'd1);
    chk("same_tv", 32'(n_tv - tvb), 32'd1);
    chk("same_temp", 32'(temp), 32'h1900);
    chk("same_alert", 32'(alert), 32'd1);

    // Reset in the middle of WAIT; the late completion must be ignored.
    rq.push_back('{nack: 1'b0, data: 16'h1234, dly: 6});
    pulse_req();
    wait_start("rstw_start", 10);
    cycles(2);
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
    b = st_cyc.size();
    tvb = n_tv;
    @(negedge clk);
    chk("rstw_temp", 32'(temp), 32'd0);
    chk("rstw_alert", 32'(alert), 32'd0);
    chk("rstw_err", 32'(err), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_start0", 32'(sns_start), 32'd0);
    chk("rstw_tv0", 32'(temp_valid), 32'd0);
    cycles(8);
    chk("rstw_late_temp", 32'(temp), 32'd0);
    chk("rstw_late_tv", 32'(n_tv - tvb), 32'd0);
    chk("rstw_late_starts", 32'(st_cyc.size() - b), 32'd0);
    chk("rstw_late_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
